adbg_lint_burst_ctrl: RTL

- Burst command engine that sits directly upstream of the debug LINT bus interface unit (BIU) and drives its strobe/ready transaction port.
- Takes one burst command (start address, access size, word count, direction) from the debug command decoder.
- Issues one BIU transaction per word, auto-incrementing the address, and streams write data in and read data out with valid/ready handshakes.
- Justifies data to the BIU lane conventions: write data is MSB-justified on the BIU data input; read data from the BIU is LSB-justified.

---
 rtl/adbg_lint_burst_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/adbg_lint_burst_ctrl.sv
// Burst command engine in front of the debug LINT BIU: one BIU transaction per
// word, auto-incrementing address, MSB-justified write lanes, LSB-justified reads.
module adbg_lint_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  trstn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_rd_wrn_i,
    input  logic [3:0]            cmd_size_i,
    input  logic [CNT_WIDTH-1:0]  cmd_count_i,
    input  logic                  abort_i,
    input  logic                  wdata_valid_i,
    input  logic [63:0]           wdata_i,
    output logic                  wdata_ready_o,
    output logic                  rdata_valid_o,
    output logic [63:0]           rdata_o,
    input  logic                  rdata_ready_i,
    output logic                  biu_strobe_o,
    output logic                  biu_rd_wrn_o,
    output logic [ADDR_WIDTH-1:0] biu_addr_o,
    output logic [63:0]           biu_data_o,
    output logic [3:0]            biu_word_size_o,
    input  logic                  biu_rdy_i,
    input  logic [63:0]           biu_data_i,
    input  logic                  biu_err_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StRdout, StDone} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_size;
    logic                  r_rd_wrn;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_abort;
    logic                  r_err;
    logic [63:0]           r_rdata;
    logic                  r_rdata_valid;

    logic                  w_size_ok;
    logic                  w_misaligned;
    logic                  w_abort;
    logic                  w_strobe;
    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  w_cnt_dec;
    logic [63:0]           w_wdata_msb;
    logic [63:0]           w_rdata_mask;

    assign w_size_ok    = cmd_size_i inside {4'd1, 4'd2, 4'd4, 4'd8};
    // Only meaningful for legal sizes (power of two up to 8).
    assign w_misaligned = |(cmd_addr_i[3:0] & (cmd_size_i - 4'd1));
    // An abort in the current cycle counts as well as a latched one.
    assign w_abort      = r_abort | abort_i;
    assign w_accept     = w_strobe & biu_rdy_i;
    assign w_cnt_dec    = r_count - CNT_WIDTH'(1);

    // Byte-lane justification: writes to the MSB end, reads masked to size bytes.
    always_comb begin
        w_wdata_msb  = wdata_i;
        w_rdata_mask = biu_data_i;
        case (r_size)
            4'd1: begin
                w_wdata_msb  = {wdata_i[7:0], 56'd0};
                w_rdata_mask = {56'd0, biu_data_i[7:0]};
            end
            4'd2: begin
                w_wdata_msb  = {wdata_i[15:0], 48'd0};
                w_rdata_mask = {48'd0, biu_data_i[15:0]};
            end
            4'd4: begin
                w_wdata_msb  = {wdata_i[31:0], 32'd0};
                w_rdata_mask = {32'd0, biu_data_i[31:0]};
            end
            default: begin
                w_wdata_msb  = wdata_i;
                w_rdata_mask = biu_data_i;
            end
        endcase
    end

    // Next-state decode and BIU strobe generation.
    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        case (r_state)
            StIdle: begin
                if (cmd_valid_i) begin
                    if (!w_size_ok || w_misaligned || (cmd_count_i == '0)) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StIssue;
                    end
                end
            end
            StIssue: begin
                if (w_abort) begin
                    w_state_nxt = StDone;
                end else begin
                    w_strobe = r_rd_wrn | wdata_valid_i;
                    if (w_strobe && biu_rdy_i) begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (biu_rdy_i) begin
                    if (r_rd_wrn) begin
                        w_state_nxt = StRdout;
                    end else if ((w_cnt_dec != '0) && !w_abort) begin
                        w_state_nxt = StIssue;
                    end else begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StRdout: begin
                // r_count was already decremented when the word completed.
                if (rdata_ready_i) begin
                    w_state_nxt = ((r_count != '0) && !w_abort) ? StIssue : StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context, abort latch, error and read-data registers.
    always_ff @(posedge clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_addr        <= '0;
            r_size        <= '0;
            r_rd_wrn      <= 1'b1;
            r_count       <= '0;
            r_abort       <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            if (r_state == StIdle) begin
                r_abort <= 1'b0;
            end else if (abort_i) begin
                r_abort <= 1'b1;
            end
            if ((r_state == StIdle) && cmd_valid_i) begin
                r_addr   <= cmd_addr_i;
                r_size   <= cmd_size_i;
                r_rd_wrn <= cmd_rd_wrn_i;
                r_count  <= cmd_count_i;
                r_err    <= !w_size_ok || w_misaligned;
            end
            if ((r_state == StWait) && biu_rdy_i) begin
                r_err   <= r_err | biu_err_i;
                r_addr  <= r_addr + ADDR_WIDTH'(r_size);
                r_count <= w_cnt_dec;
                if (r_rd_wrn) begin
                    r_rdata       <= w_rdata_mask;
                    r_rdata_valid <= 1'b1;
                end
            end
            if ((r_state == StRdout) && rdata_ready_i) begin
                r_rdata_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready_o     = (r_state == StIdle);
    assign busy_o          = (r_state != StIdle);
    assign done_o          = (r_state == StDone);
    assign err_o           = r_err;
    assign wdata_ready_o   = w_accept & ~r_rd_wrn;
    assign rdata_valid_o   = r_rdata_valid;
    assign rdata_o         = r_rdata;
    assign biu_strobe_o    = w_strobe;
    assign biu_rd_wrn_o    = r_rd_wrn;
    assign biu_addr_o      = r_addr;
    assign biu_word_size_o = r_size;
    assign biu_data_o      = ((r_state == StIssue) && !r_rd_wrn) ? w_wdata_msb : '0;

endmodule
